// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings for the data-processing control path: FSM states, PC mux selects,
// ARM condition codes and the undefined-instruction vector.
package cpu_ctrl_pkg;

   localparam int unsigned STATE_W = 3;

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_FETCH   = 3'd1;
   localparam logic [2:0] S_DECODE  = 3'd2;
   localparam logic [2:0] S_READ    = 3'd3;
   localparam logic [2:0] S_READ_RS = 3'd4;
   localparam logic [2:0] S_EXEC    = 3'd5;
   localparam logic [2:0] S_WB      = 3'd6;
   localparam logic [2:0] S_UND     = 3'd7;

   localparam logic [1:0] PCSEL_INC = 2'd0;
   localparam logic [1:0] PCSEL_ALU = 2'd1;
   localparam logic [1:0] PCSEL_UND = 2'd2;

   localparam logic [3:0] EQ = 4'h0;
   localparam logic [3:0] NE = 4'h1;
   localparam logic [3:0] CS = 4'h2;
   localparam logic [3:0] CC = 4'h3;
   localparam logic [3:0] MI = 4'h4;
   localparam logic [3:0] PL = 4'h5;
   localparam logic [3:0] VS = 4'h6;
   localparam logic [3:0] VC = 4'h7;
   localparam logic [3:0] HI = 4'h8;
   localparam logic [3:0] LS = 4'h9;
   localparam logic [3:0] GE = 4'hA;
   localparam logic [3:0] LT = 4'hB;
   localparam logic [3:0] GT = 4'hC;
   localparam logic [3:0] LE = 4'hD;
   localparam logic [3:0] AL = 4'hE;
   localparam logic [3:0] NV = 4'hF;

   // Consumed by the datapath PC mux on the PCSEL_UND leg.
   localparam logic [31:0] UND_VECTOR = 32'h0000_0004;

endpackage

// File: rtl/cond_check.sv
// ARM condition-code evaluator: pass is high when cond holds for the given NZCV flags.
module cond_check
   import cpu_ctrl_pkg::*;
(
   input  logic [3:0] cond,
   input  logic [3:0] nzcv,
   output logic       pass
);

   logic n, z, c, v;
   assign {n, z, c, v} = nzcv;

   always_comb begin
      pass = 1'b0;
      case (cond)
         EQ:      pass = z;
         NE:      pass = !z;
         CS:      pass = c;
         CC:      pass = !c;
         MI:      pass = n;
         PL:      pass = !n;
         VS:      pass = v;
         VC:      pass = !v;
         HI:      pass = c && !z;
         LS:      pass = !c || z;
         GE:      pass = (n == v);
         LT:      pass = (n != v);
         GT:      pass = !z && (n == v);
         LE:      pass = z || (n != v);
         AL:      pass = 1'b1;
         default: pass = 1'b0;
      endcase
   end

endmodule

// File: rtl/dp_exec_ctrl.sv
// Multi-cycle sequencer for the data-processing datapath: fetch, decode, condition
// check, operand read, execute and writeback, with undefined-instruction trap.
module dp_exec_ctrl
   import cpu_ctrl_pkg::*;
#(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             run,
   input  logic             imem_ack,
   input  logic [3:0]       cond,
   input  logic [3:0]       nzcv,
   input  logic             und_ins,
   input  logic [1:0]       rs_imm_s,
   input  logic             ttcc,
   input  logic             s_bit,
   output logic             imem_req,
   output logic             ir_we,
   output logic             pc_we,
   output logic [1:0]       pc_sel,
   output logic             rf_rd_ab_en,
   output logic             rf_rd_s_en,
   output logic             alu_res_we,
   output logic             flag_we,
   output logic             rf_we,
   output logic             und_trap,
   output logic             busy,
   output logic [2:0]       state,
   output logic [CNT_W-1:0] retired_cnt
);

   logic [STATE_W-1:0] state_q, state_d;
   logic               cond_pass;
   logic               retire;
   logic [2:0]         after_done;

   cond_check u_cond_check (
      .cond (cond),
      .nzcv (nzcv),
      .pass (cond_pass)
   );

   assign state      = state_q;
   assign busy       = (state_q != S_IDLE);
   assign after_done = run ? S_FETCH : S_IDLE;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   // Next state and Moore outputs; only the FETCH write enables look at imem_ack.
   always_comb begin
      state_d     = state_q;
      imem_req    = 1'b0;
      ir_we       = 1'b0;
      pc_we       = 1'b0;
      pc_sel      = PCSEL_INC;
      rf_rd_ab_en = 1'b0;
      rf_rd_s_en  = 1'b0;
      alu_res_we  = 1'b0;
      flag_we     = 1'b0;
      rf_we       = 1'b0;
      und_trap    = 1'b0;
      retire      = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            imem_req = 1'b1;
            if (imem_ack) begin
               ir_we   = 1'b1;
               pc_we   = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            if (und_ins)         state_d = S_UND;
            else if (!cond_pass) state_d = after_done;
            else                 state_d = S_READ;
         end
         S_READ: begin
            rf_rd_ab_en = 1'b1;
            state_d     = (rs_imm_s == 2'b01) ? S_READ_RS : S_EXEC;
         end
         S_READ_RS: begin
            rf_rd_s_en = 1'b1;
            state_d    = S_EXEC;
         end
         S_EXEC: begin
            alu_res_we = 1'b1;
            flag_we    = s_bit | ttcc;
            if (ttcc) begin
               retire  = 1'b1;
               state_d = after_done;
            end else begin
               state_d = S_WB;
            end
         end
         S_WB: begin
            rf_we   = 1'b1;
            retire  = 1'b1;
            state_d = after_done;
         end
         S_UND: begin
            und_trap = 1'b1;
            pc_we    = 1'b1;
            pc_sel   = PCSEL_UND;
            state_d  = after_done;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Retired-instruction counter, wraps naturally at 2^CNT_W.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)      retired_cnt <= '0;
      else if (retire) retired_cnt <= retired_cnt + CNT_W'(1);
   end

endmodule

// File: doc/dp_exec_ctrl.md
Name: dp_exec_ctrl

Overview:
Multi-cycle control FSM that sequences the ARM data-processing datapath: instruction fetch, decode, condition check, register read, shift/ALU execute, and writeback.
- Consumes the decoded fields the instruction decoder derives combinationally from IR.
- Drives the enables for IR, PC, register file, operand latches, ALU result register and NZCV flags.
- Traps undefined instructions to a fixed vector and counts retired instructions.

Parameters:
UND_VECTOR, 32'h0000_0004, PC value loaded on an undefined-instruction trap (a constant on pc_sel==2 path; exported for the datapath mux)
CNT_W, 32, width of retired-instruction counter

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
run  in  1  enables instruction sequencing
imem_ack  in  1  instruction memory has IR data valid this cycle
cond  in  4  IR[31:28] condition code
nzcv  in  4  current flags {N,Z,C,V}
und_ins  in  1  decoder: undefined instruction
rs_imm_s  in  2  decoder: 2'b01 = register-specified shift (needs Rs read)
ttcc  in  1  decoder: TST/TEQ/CMP/CMN (no Rd write)
s_bit  in  1  decoder: S field
imem_req  out  1  instruction fetch request
ir_we  out  1  load IR
pc_we  out  1  load PC
pc_sel  out  2  0: PC+4, 1: ALU result, 2: UND_VECTOR
rf_rd_ab_en  out  1  latch Rn/Rm operands
rf_rd_s_en  out  1  latch Rs operand
alu_res_we  out  1  latch ALU/shifter result
flag_we  out  1  update NZCV
rf_we  out  1  write Rd
und_trap  out  1  one-cycle undefined-instruction pulse
busy  out  1  state != IDLE
state  out  3  current state encoding, for debug
retired_cnt  out  CNT_W  executed-instruction count

Behaviour:
- States: IDLE=0, FETCH=1, DECODE=2, READ=3, READ_RS=4, EXEC=5, WB=6, UND=7.
- Reset: state=IDLE, retired_cnt=0, all outputs 0, pc_sel=0.
- Reset asserted mid-instruction aborts the instruction immediately; no partial write completes.
- IDLE: if run=1, go to FETCH next cycle.
- FETCH: imem_req=1 and held until imem_ack.
  - In the ack cycle: ir_we=1, pc_we=1, pc_sel=0; next state is DECODE.
  - Wait cycles are unbounded.
- DECODE: decoder fields are valid from IR. Priority:
  - und_ins=1 -> UND.
  - Condition fails -> FETCH if run, else IDLE. This is a skip: no counter increment.
  - Otherwise -> READ.
- Condition codes follow ARM semantics:
  - EQ Z, NE !Z, CS C, CC !C, MI N, PL !N, VS V, VC !V.
  - HI C&!Z, LS !C|Z, GE N==V, LT N!=V, GT !Z&(N==V), LE Z|(N!=V).
  - AL=1, NV(4'hF)=0.
- READ: rf_rd_ab_en=1. Next state is READ_RS if rs_imm_s==2'b01, else EXEC.
- READ_RS: rf_rd_s_en=1, then EXEC.
- EXEC: alu_res_we=1; flag_we=s_bit|ttcc.
  - If ttcc: instruction retires here and WB is skipped; next state is FETCH if run, else IDLE.
  - Otherwise: next state is WB.
- WB: retires the instruction; next state is FETCH if run, else IDLE.
  - rf_we=1.
  - Additionally, if Rd is PC the datapath steers the result into PC via pc_we=1, pc_sel=1; rd_is_pc is derived inside the datapath and is not a controller port. The controller always pulses rf_we and leaves the PC-as-Rd redirect to the datapath.
- UND: und_trap=1, pc_we=1, pc_sel=2 for one cycle, then FETCH if run, else IDLE. No retire.
- Retire: retired_cnt increments by 1 in the retiring cycle and wraps modulo 2^CNT_W.
- run deasserted mid-instruction: the current instruction completes and the FSM then enters IDLE. In FETCH with no ack yet, it keeps waiting; a fetch is never abandoned.
- All outputs are Moore-decoded from state, except ir_we/pc_we in FETCH, which are qualified by imem_ack.
- Latency, counted with ack in the first FETCH cycle:
  - Plain instruction: 5 cycles.
  - Register-shift instruction: 6 cycles.
  - ttcc instruction: 4 cycles (plus 1 if register shift).
  - Condition-fail: 2 cycles.
  - Undefined: 3 cycles.

Decomposition:
- Shared package (cpu_ctrl_pkg):
  - State encoding localparams.
  - pc_sel encodings PCSEL_INC/PCSEL_ALU/PCSEL_UND.
  - Condition code constants EQ..NV.
- One sub-module, cond_check: combinational, inputs cond[3:0] and nzcv[3:0], output pass. Reused later by the branch unit.

Test Plan:
- Reset/idle: rst_n low then high with run=0 -> state=0, all outputs 0, retired_cnt=0; then run=1 -> state=1, imem_req=1 next cycle.
- Plain ADD, AL: cond=4'hE, und_ins=0, rs_imm_s=0, ttcc=0, s_bit=1, imem_ack=1 -> states 1,2,3,5,6, flag_we=1 in EXEC, rf_we=1 in WB, retired_cnt=1.
- Register shift plus fetch wait: rs_imm_s=2'b01, imem_ack delayed 3 cycles -> imem_req high 4 cycles, ir_we single pulse, READ_RS visited, 9 cycles total.
- CMP: ttcc=1, s_bit=1 -> flag_we=1 in EXEC, rf_we never asserted, WB skipped, counter +1.
- Condition fail: cond=EQ(4'h0) with nzcv=4'b0000 -> DECODE back to FETCH, no rf_we/flag_we, counter unchanged.
  - Also cond=4'hF -> same skip.
- Undefined and reset abort:
  - und_ins=1 -> UND: und_trap=1, pc_we=1, pc_sel=2 for one cycle, counter unchanged.
  - rst_n low during EXEC -> asynchronous return to IDLE with no WB pulse.
